// File: rtl/fifo_burst_reader.sv
// Burst read master for the 8-bit sfifo: pops LEN words and streams them
// out on valid/ready through a two-entry skid buffer.
module fifo_burst_reader #(
  parameter int DW   = 8,
  parameter int LENW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [LENW-1:0] len,
  input  logic            abort,
  input  logic            fifo_empty,
  input  logic [DW-1:0]   fifo_dout,
  output logic            fifo_re,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  input  logic            m_ready,
  output logic            busy,
  output logic            done,
  output logic            aborted,
  output logic [LENW-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    FINISH
  } state_t;

  state_t          state;
  logic [LENW-1:0] rem;
  logic [LENW-1:0] len_q;
  logic            inflight;
  logic [1:0]      cnt;
  logic [DW-1:0]   tail;

  logic       pop;
  logic       push;
  logic       last;
  logic [1:0] occ;

  assign pop  = m_valid & m_ready;
  assign push = inflight;
  assign occ  = cnt + {1'b0, inflight};
  assign last = pop && ((xfer_cnt + LENW'(1)) == len_q);

  // Read only if the word can land even when nothing drains this cycle.
  assign fifo_re = !rst
                && (state == BURST)
                && !fifo_empty
                && (rem != '0)
                && ((occ - {1'b0, pop}) < 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rem      <= '0;
      len_q    <= '0;
      inflight <= 1'b0;
      cnt      <= 2'd0;
      tail     <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      done     <= 1'b0;
      aborted  <= 1'b0;
      inflight <= fifo_re;
      if (fifo_re) begin
        rem <= rem - LENW'(1);
      end

      case ({push, pop})
        2'b11: begin
          if (cnt == 2'd2) begin
            m_data <= tail;
            tail   <= fifo_dout;
          end else begin
            m_data <= fifo_dout;
          end
        end
        2'b10: begin
          if (cnt == 2'd0) begin
            m_data <= fifo_dout;
          end else begin
            tail <= fifo_dout;
          end
          cnt     <= cnt + 2'd1;
          m_valid <= 1'b1;
        end
        2'b01: begin
          m_data  <= tail;
          cnt     <= cnt - 2'd1;
          m_valid <= (cnt == 2'd2);
        end
        default: ;
      endcase

      case (state)
        IDLE: begin
          if (start) begin
            xfer_cnt <= '0;
            if (len != '0) begin
              rem   <= len;
              len_q <= len;
              busy  <= 1'b1;
              state <= BURST;
            end else begin
              state <= FINISH;
            end
          end
        end
        BURST: begin
          // Abort drops buffered and in-flight data; the count is frozen.
          if (abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            cnt      <= 2'd0;
            m_valid  <= 1'b0;
            inflight <= 1'b0;
            rem      <= '0;
          end else if (pop) begin
            xfer_cnt <= xfer_cnt + LENW'(1);
            if (last) begin
              busy  <= 1'b0;
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural sfifo model
// and a negedge stream monitor.
module tb_fifo_burst_reader;

  localparam int DW   = 8;
  localparam int LENW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [LENW-1:0] len = '0;
  logic            abort = 1'b0;
  logic            fifo_empty = 1'b1;
  logic [DW-1:0]   fifo_dout = '0;
  logic            m_ready = 1'b0;
  logic            fifo_re;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            busy;
  logic            done;
  logic            aborted;
  logic [LENW-1:0] xfer_cnt;

  fifo_burst_reader #(.DW(DW), .LENW(LENW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .fifo_empty(fifo_empty),
    .fifo_dout (fifo_dout),
    .fifo_re   (fifo_re),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .xfer_cnt  (xfer_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] rx[$];
  logic          re_s = 1'b0;
  int rd_n, xf_n, run, run_max, xrun, xrun_max;
  int n_done, n_abort, occ_viol, stab_viol;
  logic          hold = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          mon_p;

  // sfifo model: one-cycle registered read.
  always @(posedge clk) begin
    if (re_s && q.size() > 0) begin
      fifo_dout  <= q.pop_front();
      fifo_empty <= (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    mon_p = m_valid & m_ready;
    re_s  = fifo_re;
    if (fifo_re && (rd_n - xf_n - int'(mon_p)) >= 2) occ_viol++;
    if (hold && (m_valid !== 1'b1 || m_data !== hold_d)) stab_viol++;
    hold   = m_valid & !m_ready & !abort & !rst;
    hold_d = m_data;
    if (fifo_re) begin
      rd_n++;
      run++;
      if (run > run_max) run_max = run;
    end else begin
      run = 0;
    end
    if (mon_p) begin
      xf_n++;
      rx.push_back(m_data);
      xrun++;
      if (xrun > xrun_max) xrun_max = xrun;
    end else begin
      xrun = 0;
    end
    if (done) n_done++;
    if (aborted) n_abort++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_n = 0; xf_n = 0; run = 0; run_max = 0; xrun = 0; xrun_max = 0;
    n_done = 0; n_abort = 0; occ_viol = 0; stab_viol = 0; hold = 1'b0;
    rx.delete();
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) q.push_back(DW'(first + i));
    fifo_empty = (q.size() == 0);
  endtask

  task automatic do_start(input int l);
    len   = LENW'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit tog, input string nm);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      if (tog) m_ready = (k % 2 == 0);
      tick();
      k++;
    end
    m_ready = 1'b1;
    n_checks++;
    if (n_done == 0) begin
      n_fail++;
      $display("FAIL %s_timeout got no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    n_checks++;
    if ({fifo_re, m_valid, busy, done, aborted} !== 5'b0) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 00000",
               {fifo_re, m_valid, busy, done, aborted});
    end
    n_checks++;
    if (m_data !== '0 || xfer_cnt !== '0) begin
      n_fail++;
      $display("FAIL rst_data got %h/%0d want 0/0", m_data, xfer_cnt);
    end
    tick();
    rst = 1'b0;
    clr();
  endtask

  task automatic test_full_rate();
    clr();
    load(1, 16);
    m_ready = 1'b1;
    do_start(16);
    @(negedge clk);
    n_checks++;
    if (fifo_re !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_first_re got re=%b v=%b want 1/0", fifo_re, m_valid);
    end
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_lat_early got v=%b want 0", m_valid);
    end
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 8'd1) begin
      n_fail++;
      $display("FAIL t1_lat got v=%b d=%0d want 1/1", m_valid, m_data);
    end
    tick();
    wait_done(40, 1'b0, "t1");
    tick();
    tick();
    n_checks++;
    if (run_max != 16 || xrun_max != 16) begin
      n_fail++;
      $display("FAIL t1_runs got re=%0d xf=%0d want 16/16", run_max, xrun_max);
    end
    n_checks++;
    if (rx.size() != 16) begin
      n_fail++;
      $display("FAIL t1_count got %0d want 16", rx.size());
    end
    for (int i = 0; i < 16 && i < rx.size(); i++) begin
      n_checks++;
      if (rx[i] !== DW'(i + 1)) begin
        n_fail++;
        $display("FAIL t1_data[%0d] got %0d want %0d", i, rx[i], i + 1);
      end
    end
    n_checks++;
    if (n_done != 1 || xfer_cnt !== 5'd16 || fifo_empty !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t1_end got done=%0d cnt=%0d empty=%b busy=%b want 1/16/1/0",
               n_done, xfer_cnt, fifo_empty, busy);
    end
  endtask

  task automatic test_backpressure();
    clr();
    load(1, 8);
    m_ready = 1'b1;
    do_start(8);
    wait_done(60, 1'b1, "t2");
    tick();
    tick();
    n_checks++;
    if (rx.size() != 8) begin
      n_fail++;
      $display("FAIL t2_count got %0d want 8", rx.size());
    end
    for (int i = 0; i < 8 && i < rx.size(); i++) begin
      n_checks++;
      if (rx[i] !== DW'(i + 1)) begin
        n_fail++;
        $display("FAIL t2_data[%0d] got %0d want %0d", i, rx[i], i + 1);
      end
    end
    n_checks++;
    if (stab_viol != 0 || occ_viol != 0) begin
      n_fail++;
      $display("FAIL t2_rules got stab=%0d occ=%0d want 0/0", stab_viol, occ_viol);
    end
    n_checks++;
    if (n_done != 1 || xfer_cnt !== 5'd8) begin
      n_fail++;
      $display("FAIL t2_end got done=%0d cnt=%0d want 1/8", n_done, xfer_cnt);
    end
  endtask

  task automatic test_zero_len();
    clr();
    load(50, 2);
    m_ready = 1'b1;
    do_start(0);
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_early got done=%b busy=%b want 0/0", done, busy);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL t3_done got %b want 1", done);
    end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || n_done != 1) begin
      n_fail++;
      $display("FAIL t3_pulse got done=%b n=%0d want 0/1", done, n_done);
    end
    n_checks++;
    if (rd_n != 0 || xfer_cnt !== '0 || q.size() != 2) begin
      n_fail++;
      $display("FAIL t3_noread got rd=%0d cnt=%0d q=%0d want 0/0/2",
               rd_n, xfer_cnt, q.size());
    end
    tick();
    q.delete();
    fifo_empty = 1'b1;
  endtask

  task automatic test_stall();
    clr();
    load(1, 4);
    m_ready = 1'b1;
    do_start(10);
    repeat (20) tick();
    n_checks++;
    if (rx.size() != 4 || busy !== 1'b1 || fifo_re !== 1'b0) begin
      n_fail++;
      $display("FAIL t4_stall got n=%0d busy=%b re=%b want 4/1/0",
               rx.size(), busy, fifo_re);
    end
    load(5, 6);
    wait_done(40, 1'b0, "t4");
    tick();
    n_checks++;
    if (rx.size() != 10) begin
      n_fail++;
      $display("FAIL t4_count got %0d want 10", rx.size());
    end
    for (int i = 0; i < 10 && i < rx.size(); i++) begin
      n_checks++;
      if (rx[i] !== DW'(i + 1)) begin
        n_fail++;
        $display("FAIL t4_data[%0d] got %0d want %0d", i, rx[i], i + 1);
      end
    end
    n_checks++;
    if (n_done != 1 || xfer_cnt !== 5'd10) begin
      n_fail++;
      $display("FAIL t4_end got done=%0d cnt=%0d want 1/10", n_done, xfer_cnt);
    end
  endtask

  task automatic test_abort();
    int k;
    int lost;
    clr();
    load(1, 16);
    m_ready = 1'b1;
    do_start(12);
    k = 0;
    while (xf_n < 5 && k < 40) begin
      tick();
      k++;
    end
    n_checks++;
    if (xf_n != 5) begin
      n_fail++;
      $display("FAIL t5_reach got %0d transfers want 5", xf_n);
    end
    m_ready = 1'b0;
    abort   = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    n_checks++;
    if (aborted !== 1'b1 || busy !== 1'b0 || m_valid !== 1'b0 || fifo_re !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_abort got ab=%b busy=%b v=%b re=%b want 1/0/0/0",
               aborted, busy, m_valid, fifo_re);
    end
    n_checks++;
    if (xfer_cnt !== 5'd5) begin
      n_fail++;
      $display("FAIL t5_cnt got %0d want 5", xfer_cnt);
    end
    @(negedge clk);
    n_checks++;
    if (aborted !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_pulse got %b want 0", aborted);
    end
    tick();
    tick();
    lost = 16 - q.size();
    n_checks++;
    if (n_abort != 1 || n_done != 0 || lost < 5 || lost > 7) begin
      n_fail++;
      $display("FAIL t5_end got ab=%0d done=%0d lost=%0d want 1/0/5..7",
               n_abort, n_done, lost);
    end
    for (int i = 0; i < 5 && i < rx.size(); i++) begin
      n_checks++;
      if (rx[i] !== DW'(i + 1)) begin
        n_fail++;
        $display("FAIL t5_data[%0d] got %0d want %0d", i, rx[i], i + 1);
      end
    end
    q.delete();
    fifo_empty = 1'b1;
    m_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    clr();
    load(1, 8);
    m_ready = 1'b0;
    do_start(8);
    repeat (4) tick();
    @(negedge clk);
    n_checks++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_pre got v=%b want 1", m_valid);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (fifo_re !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_re_gate got %b want 0", fifo_re);
    end
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({m_valid, fifo_re, busy, done, aborted} !== 5'b0) begin
      n_fail++;
      $display("FAIL t6_after got %b want 00000",
               {m_valid, fifo_re, busy, done, aborted});
    end
    tick();
    q.delete();
    clr();
    load(11, 3);
    m_ready = 1'b1;
    do_start(3);
    wait_done(30, 1'b0, "t6");
    tick();
    n_checks++;
    if (rx.size() != 3) begin
      n_fail++;
      $display("FAIL t6_count got %0d want 3", rx.size());
    end
    for (int i = 0; i < 3 && i < rx.size(); i++) begin
      n_checks++;
      if (rx[i] !== DW'(11 + i)) begin
        n_fail++;
        $display("FAIL t6_data[%0d] got %0d want %0d", i, rx[i], 11 + i);
      end
    end
    n_checks++;
    if (n_done != 1 || n_abort != 0 || xfer_cnt !== 5'd3) begin
      n_fail++;
      $display("FAIL t6_end got done=%0d ab=%0d cnt=%0d want 1/0/3",
               n_done, n_abort, xfer_cnt);
    end
  endtask

  initial begin
    clr();
    test_reset();
    test_full_rate();
    test_backpressure();
    test_zero_len();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fifo_burst_reader.md
Name: fifo_burst_reader

Overview:
- Read-side master for the team's 8-bit synchronous FIFO (sfifo: re/empty/dout, one-cycle registered read latency).
- On a start command, pops exactly LEN words from the FIFO and delivers them on a valid/ready stream, with full-rate throughput and backpressure.
- A two-entry skid buffer absorbs the FIFO read latency.
- Completion and abort are reported as single-cycle pulses.

Parameters:
- DW, 8: data width; matches FIFO dout.
- LENW, 5: burst length width; max burst 2^LENW-1 = 31, which exceeds the FIFO depth of 16.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  burst request; sampled only in IDLE.
- len  in  LENW  burst length; captured with start.
- abort  in  1  terminate the current burst.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DW  FIFO read data; valid the cycle after fifo_re is sampled high.
- fifo_re  out  1  FIFO read enable.
- m_valid  out  1  stream data valid.
- m_data  out  DW  stream data.
- m_ready  in  1  downstream accept.
- busy  out  1  high in BURST.
- done  out  1  one-cycle pulse: burst completed.
- aborted  out  1  one-cycle pulse: burst aborted.
- xfer_cnt  out  LENW  words delivered in the current or last burst.

Behaviour:
- Reset: the state goes to IDLE. The following are all 0: fifo_re, m_valid, m_data, busy, done, aborted, xfer_cnt. Remaining count, in-flight flag and buffer contents are cleared.
- fifo_re is forced to 0 in any cycle where rst is high. A reset mid-burst discards all buffered and in-flight data with no done or aborted pulse.
- FSM states: IDLE, BURST, FINISH.
- IDLE, start=1, len>0: capture len into rem, clear xfer_cnt, go to BURST.
- IDLE, start=1, len=0: go to FINISH. No FIFO reads occur.
- BURST, last word transferred (xfer_cnt reaches len): go to FINISH.
- BURST, abort=1: go to IDLE. In that same edge, flush the buffer, drop the in-flight word, pulse aborted next cycle, and hold xfer_cnt.
- FINISH: done=1 for exactly one cycle, then IDLE.
- start is ignored outside IDLE. abort is ignored outside BURST.
- Read issue (combinational from registered state): fifo_re = BURST & !fifo_empty & rem>0 & (occ - pop) < 2.
  - occ = buffered entries + in-flight read (0..2).
  - pop = m_valid & m_ready.
- Each fifo_re decrements rem by 1 and sets the in-flight flag. The next cycle, fifo_dout is written into the buffer tail.
- Stream output: m_valid = buffer non-empty; m_data = buffer head, registered.
- A transfer occurs on m_valid & m_ready and increments xfer_cnt.
- m_data and m_valid stay stable while m_valid & !m_ready.
- Push and pop in the same cycle are both honoured.
- Throughput: with m_ready held high and the FIFO non-empty, one word per clock.
- Latency: start sampled at edge N → fifo_re high in cycle N+1 → m_valid high after edge N+2 → done high after the edge of the last transfer plus one.
- Empty FIFO: reads stall. The FSM stays in BURST indefinitely with no timeout; abort is the only exit.
- xfer_cnt holds its value after done/aborted until the next accepted start.
- Words are never read beyond len; the FIFO retains any surplus.

Test Plan:
1. Reset, FIFO preloaded with 1..16, m_ready=1, start with len=16 → fifo_re high for 16 consecutive cycles. m_data shows 1..16 on consecutive cycles, then done pulses once, xfer_cnt=16, fifo_empty=1.
2. FIFO holds 1..8, len=8, m_ready toggling 1,0,1,0 → each word is held stable while m_ready=0. fifo_re is never high when occ=2. Output is 1..8 in order with no loss or duplication; then done.
3. len=0 start → no fifo_re. done pulses 2 cycles after start; xfer_cnt=0.
4. FIFO holds 1..4, len=10 → 4 words delivered, then the block stays busy=1 with fifo_re=0. Write 5..10 into the FIFO → delivery resumes 5..10, then done.
5. FIFO holds 1..16, len=12, abort asserted after 5 transfers → aborted pulses and xfer_cnt=5. The FIFO has lost at most 7 words. No done pulse; busy=0.
6. rst asserted mid-burst with m_valid=1 → m_valid, fifo_re and busy are 0 after the edge. A new start with len=3 then works normally.
